// File: rtl/sdram_cmd_arbiter_if.sv
// Bus bundle between the requesting masters and sdram_cmd_arbiter.
// The master modport is the requester side; the slave modport is the arbiter,
// which also drives the SDRAM command pins toward sdram_controls.
interface sdram_cmd_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*2-1:0]  req_size;
    logic [NUM_REQ-1:0]    req_stall;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    done;
    logic                  CS;
    logic                  RAS;
    logic                  CAS;
    logic                  WeIn;
    logic [AW-1:0]         AddrOut;
    logic [1:0]            SizeOut;

    modport master (
        output req, req_we, req_addr, req_size, req_stall,
        input  grant, done, CS, RAS, CAS, WeIn, AddrOut, SizeOut
    );

    modport slave (
        input  req, req_we, req_addr, req_size, req_stall,
        output grant, done, CS, RAS, CAS, WeIn, AddrOut, SizeOut
    );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter: shares one sdram_controls instance between NUM_REQ masters.
// The winner gets the sequence ROW -> CAS wait -> COL -> burst -> recovery on the
// active-low command pins {CS,RAS,CAS,WeIn}. Every output is a register that is
// loaded with the value for the cycle that follows the edge.
// Optional build macro SDRAM_ARB_FIXED_PRIO_EN: fixed priority (lowest requesting
// index wins) and no round-robin pointer; default build is round-robin.
module sdram_cmd_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [7:0]        tburst,
    input  logic [7:0]        tcas,
    input  logic [7:0]        twait,
    sdram_cmd_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);

    localparam logic [3:0] CMD_NOP   = 4'b1111;
    localparam logic [3:0] CMD_CASW  = 4'b0111;
    localparam logic [3:0] CMD_STALL = 4'b1100;

    typedef enum logic [2:0] {IDLE, ROW, CASW, COL, BURST, RECOV} state_t;

    state_t              stateReg, stateNext;
    logic [3:0]          cmdReg, cmdNext;
    logic [7:0]          cntReg, cntNext;
    logic [NUM_REQ-1:0]  grantReg, grantNext;
    logic [NUM_REQ-1:0]  doneReg, doneNext;
    logic [AW-1:0]       addrReg, addrNext;
    logic [1:0]          sizeReg, sizeNext;
    logic                wReg, wNext;
    logic [PW-1:0]       winReg, winNext;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    logic [PW-1:0]       ptrReg, ptrNext;
`endif

    logic                anyReq;
    logic [PW-1:0]       pick;
    logic [7:0]          beats;
    logic                stallNow;

    logic [AW-1:0]       addrArr [NUM_REQ];
    logic [1:0]          sizeArr [NUM_REQ];

    // Per-master views of the flattened address and size buses
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addrArr[gi] = bus.req_addr[gi*AW +: AW];
        assign sizeArr[gi] = bus.req_size[gi*2 +: 2];
    end

    // Winner selection; scanning from the far end lets the closest requester win
    always_comb begin
        anyReq = 1'b0;
        pick   = '0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                anyReq = 1'b1;
                pick   = PW'(i);
            end
        end
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int            idx;
            logic [PW-1:0] idxSel;
            idx = int'(ptrReg) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idxSel = PW'(idx);
            if (bus.req[idxSel]) begin
                anyReq = 1'b1;
                pick   = idxSel;
            end
        end
`endif
    end

    assign beats    = (tburst == 8'd0) ? 8'd1 : tburst;
    assign stallNow = bus.req_stall[winReg];

    // Next-state and next-output logic for the command sequencer
    always_comb begin
        stateNext = stateReg;
        cmdNext   = cmdReg;
        cntNext   = cntReg;
        grantNext = grantReg;
        doneNext  = '0;
        addrNext  = addrReg;
        sizeNext  = sizeReg;
        wNext     = wReg;
        winNext   = winReg;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        ptrNext   = ptrReg;
`endif
        case (stateReg)
            IDLE: begin
                cmdNext = CMD_NOP;
                if (anyReq) begin
                    stateNext = ROW;
                    winNext   = pick;
                    grantNext = NUM_REQ'(1) << pick;
                    addrNext  = addrArr[pick];
                    sizeNext  = sizeArr[pick];
                    wNext     = ~bus.req_we[pick];
                    cmdNext   = {3'b001, ~bus.req_we[pick]};
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                    ptrNext   = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + PW'(1);
`endif
                end
            end
            ROW: begin
                if (tcas == 8'd0) begin
                    stateNext = COL;
                    cmdNext   = {3'b010, wReg};
                end else begin
                    stateNext = CASW;
                    cmdNext   = CMD_CASW;
                    cntNext   = tcas;
                end
            end
            CASW: begin
                if (cntReg <= 8'd1) begin
                    stateNext = COL;
                    cmdNext   = {3'b010, wReg};
                    cntNext   = 8'd0;
                end else begin
                    cntNext   = cntReg - 8'd1;
                end
            end
            COL: begin
                // cntReg in BURST counts beats still to be issued after the current cycle
                stateNext = BURST;
                if (stallNow) begin
                    cmdNext = CMD_STALL;
                    cntNext = beats;
                end else begin
                    cmdNext  = {3'b011, wReg};
                    cntNext  = beats - 8'd1;
                    doneNext = (beats == 8'd1) ? grantReg : '0;
                end
            end
            BURST: begin
                if (cntReg == 8'd0) begin
                    grantNext = '0;
                    cmdNext   = CMD_NOP;
                    if (twait == 8'd0) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext = RECOV;
                        cntNext   = twait;
                    end
                end else if (stallNow) begin
                    cmdNext = CMD_STALL;
                end else begin
                    cmdNext  = {3'b011, wReg};
                    cntNext  = cntReg - 8'd1;
                    doneNext = (cntReg == 8'd1) ? grantReg : '0;
                end
            end
            RECOV: begin
                cmdNext = CMD_NOP;
                if (cntReg <= 8'd1) begin
                    stateNext = IDLE;
                    cntNext   = 8'd0;
                end else begin
                    cntNext   = cntReg - 8'd1;
                end
            end
            default: begin
                stateNext = IDLE;
                cmdNext   = CMD_NOP;
                grantNext = '0;
                cntNext   = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateReg <= IDLE;
            cmdReg   <= CMD_NOP;
            cntReg   <= 8'd0;
            grantReg <= '0;
            doneReg  <= '0;
            addrReg  <= '0;
            sizeReg  <= 2'b00;
            wReg     <= 1'b0;
            winReg   <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            ptrReg   <= '0;
`endif
        end else begin
            stateReg <= stateNext;
            cmdReg   <= cmdNext;
            cntReg   <= cntNext;
            grantReg <= grantNext;
            doneReg  <= doneNext;
            addrReg  <= addrNext;
            sizeReg  <= sizeNext;
            wReg     <= wNext;
            winReg   <= winNext;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            ptrReg   <= ptrNext;
`endif
        end
    end

    assign bus.CS      = cmdReg[3];
    assign bus.RAS     = cmdReg[2];
    assign bus.CAS     = cmdReg[1];
    assign bus.WeIn    = cmdReg[0];
    assign bus.grant   = grantReg;
    assign bus.done    = doneReg;
    assign bus.AddrOut = addrReg;
    assign bus.SizeOut = sizeReg;
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed testbench for sdram_cmd_arbiter (NUM_REQ=2, AW=32).
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_sdram_cmd_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tburst = 8'd0;
    logic [7:0] tcas = 8'd0;
    logic [7:0] twait = 8'd0;
    logic [3:0] cmd;
    int         nCompared = 0;
    int         nMismatched = 0;

    sdram_cmd_arbiter_if #(.NUM_REQ(2), .AW(32)) bus ();

    sdram_cmd_arbiter #(.NUM_REQ(2), .AW(32)) dut (
        .Clk    (clk),
        .Rst    (rst),
        .tburst (tburst),
        .tcas   (tcas),
        .twait  (twait),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign cmd = {bus.CS, bus.RAS, bus.CAS, bus.WeIn};

    task automatic test_reset();
        bus.req = 2'b00; bus.req_we = 2'b00; bus.req_addr = '0;
        bus.req_size = '0; bus.req_stall = 2'b00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nCompared++; if (cmd !== 4'b1111) begin nMismatched++; $display("FAIL reset_cmd: got %b want 1111", cmd); end
        nCompared++; if (bus.grant !== 2'b00) begin nMismatched++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
        nCompared++; if (bus.done !== 2'b00) begin nMismatched++; $display("FAIL reset_done: got %b want 00", bus.done); end
        nCompared++; if (bus.AddrOut !== 32'h0) begin nMismatched++; $display("FAIL reset_addr: got %h want 0", bus.AddrOut); end
        nCompared++; if (bus.SizeOut !== 2'b00) begin nMismatched++; $display("FAIL reset_size: got %b want 00", bus.SizeOut); end
        rst = 1'b0;
        @(negedge clk);
        nCompared++; if (cmd !== 4'b1111) begin nMismatched++; $display("FAIL reset_idle_cmd: got %b want 1111", cmd); end
        $display("test_reset: reset state checked");
    endtask

    task automatic test_single();
        logic [3:0] expCmd [11] = '{4'b0010, 4'b0111, 4'b0111, 4'b0100, 4'b0110, 4'b0110,
                                    4'b0110, 4'b0110, 4'b1111, 4'b1111, 4'b1111};
        logic [1:0] expDone [11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                     2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        logic [1:0] expGrant [11] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                                      2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        tcas = 8'd2; tburst = 8'd4; twait = 8'd3;
        bus.req_we = 2'b01; bus.req_addr[31:0] = 32'h0000_1234; bus.req_size[1:0] = 2'b10;
        bus.req = 2'b01;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 7) bus.req = 2'b00;
            nCompared++; if (cmd !== expCmd[i]) begin nMismatched++; $display("FAIL single_cmd[%0d]: got %b want %b", i, cmd, expCmd[i]); end
            nCompared++; if (bus.done !== expDone[i]) begin nMismatched++; $display("FAIL single_done[%0d]: got %b want %b", i, bus.done, expDone[i]); end
            nCompared++; if (bus.grant !== expGrant[i]) begin nMismatched++; $display("FAIL single_grant[%0d]: got %b want %b", i, bus.grant, expGrant[i]); end
            if (i == 0) begin
                nCompared++; if (bus.AddrOut !== 32'h0000_1234) begin nMismatched++; $display("FAIL single_addr: got %h want 00001234", bus.AddrOut); end
                nCompared++; if (bus.SizeOut !== 2'b10) begin nMismatched++; $display("FAIL single_size: got %b want 10", bus.SizeOut); end
            end
        end
        @(negedge clk);
        nCompared++; if (cmd !== 4'b1111 || bus.grant !== 2'b00) begin nMismatched++; $display("FAIL single_idle: got cmd %b grant %b want 1111 00", cmd, bus.grant); end
        $display("test_single: write transaction of 4 beats checked");
    endtask

    task automatic test_round_robin();
        int          t;
        int          m;
        logic [1:0]  expG;
        logic [31:0] expA;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tcas = 8'd1; tburst = 8'd2; twait = 8'd1;
        bus.req_we = 2'b00;
        bus.req_addr = {32'h2000_0000, 32'h1000_0000};
        bus.req = 2'b11;
        // Each transaction: ROW, CASW, COL, 2 beats, RECOV, IDLE = 7 cycles
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            t = (c - 1) / 7;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            m = 0;
`else
            m = t % 2;
`endif
            expG = (m == 0) ? 2'b01 : 2'b10;
            expA = (m == 0) ? 32'h1000_0000 : 32'h2000_0000;
            if ((c - 1) % 7 == 0) begin
                nCompared++; if (bus.grant !== expG) begin nMismatched++; $display("FAIL rr_grant[t%0d]: got %b want %b", t, bus.grant, expG); end
                nCompared++; if (cmd !== 4'b0011) begin nMismatched++; $display("FAIL rr_row[t%0d]: got %b want 0011", t, cmd); end
                nCompared++; if (bus.AddrOut !== expA) begin nMismatched++; $display("FAIL rr_addr[t%0d]: got %h want %h", t, bus.AddrOut, expA); end
            end
            if (c % 7 == 5) begin
                nCompared++; if (bus.done !== expG) begin nMismatched++; $display("FAIL rr_done[t%0d]: got %b want %b", t, bus.done, expG); end
            end else begin
                nCompared++; if (bus.done !== 2'b00) begin nMismatched++; $display("FAIL rr_nodone[c%0d]: got %b want 00", c, bus.done); end
            end
            if (c == 26) bus.req = 2'b00;
        end
        repeat (3) @(negedge clk);
        nCompared++; if (cmd !== 4'b1111 || bus.grant !== 2'b00) begin nMismatched++; $display("FAIL rr_idle: got cmd %b grant %b want 1111 00", cmd, bus.grant); end
        $display("test_round_robin: four contended transactions checked");
    endtask

    task automatic test_stall();
        logic [3:0] expCmd [8] = '{4'b0010, 4'b0100, 4'b0110, 4'b1100, 4'b1100, 4'b0110, 4'b0110, 4'b1111};
        logic [1:0] expDone [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        tcas = 8'd0; tburst = 8'd3; twait = 8'd0;
        bus.req_we = 2'b01; bus.req_addr[31:0] = 32'h0000_0040;
        bus.req_stall = 2'b10;   // the idle master's stall must be ignored
        bus.req = 2'b01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) bus.req_stall[0] = 1'b1;
            if (i == 4) bus.req_stall[0] = 1'b0;
            if (i == 6) bus.req = 2'b00;
            nCompared++; if (cmd !== expCmd[i]) begin nMismatched++; $display("FAIL stall_cmd[%0d]: got %b want %b", i, cmd, expCmd[i]); end
            nCompared++; if (bus.done !== expDone[i]) begin nMismatched++; $display("FAIL stall_done[%0d]: got %b want %b", i, bus.done, expDone[i]); end
        end
        bus.req_stall = 2'b00;
        $display("test_stall: two stalled cycles inside a 3-beat burst checked");
    endtask

    task automatic test_boundary();
        logic [3:0] expCmd [5] = '{4'b0011, 4'b0101, 4'b0111, 4'b1111, 4'b1111};
        logic [1:0] expDone [5] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        logic [1:0] expGrant [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        tcas = 8'd0; tburst = 8'd0; twait = 8'd0;
        bus.req_we = 2'b00; bus.req_addr[63:32] = 32'h0000_0800;
        bus.req = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) bus.req = 2'b00;
            nCompared++; if (cmd !== expCmd[i]) begin nMismatched++; $display("FAIL bound_cmd[%0d]: got %b want %b", i, cmd, expCmd[i]); end
            nCompared++; if (bus.done !== expDone[i]) begin nMismatched++; $display("FAIL bound_done[%0d]: got %b want %b", i, bus.done, expDone[i]); end
            nCompared++; if (bus.grant !== expGrant[i]) begin nMismatched++; $display("FAIL bound_grant[%0d]: got %b want %b", i, bus.grant, expGrant[i]); end
        end
        $display("test_boundary: zero tcas/tburst/twait read checked");
    endtask

    task automatic test_reset_mid();
        logic [3:0] expCmd [5] = '{4'b0010, 4'b0111, 4'b0100, 4'b0110, 4'b0110};
        tcas = 8'd1; tburst = 8'd4; twait = 8'd2;
        bus.req_we = 2'b01; bus.req_addr[31:0] = 32'h0000_5555; bus.req_size[1:0] = 2'b11;
        bus.req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nCompared++; if (cmd !== expCmd[i]) begin nMismatched++; $display("FAIL rmid_cmd[%0d]: got %b want %b", i, cmd, expCmd[i]); end
        end
        rst = 1'b1;   // sampled during the 2nd beat
        @(negedge clk);
        nCompared++; if (cmd !== 4'b1111) begin nMismatched++; $display("FAIL rmid_cmd_after: got %b want 1111", cmd); end
        nCompared++; if (bus.grant !== 2'b00) begin nMismatched++; $display("FAIL rmid_grant_after: got %b want 00", bus.grant); end
        nCompared++; if (bus.done !== 2'b00) begin nMismatched++; $display("FAIL rmid_done_after: got %b want 00", bus.done); end
        nCompared++; if (bus.AddrOut !== 32'h0 || bus.SizeOut !== 2'b00) begin nMismatched++; $display("FAIL rmid_addr_after: got %h/%b want 0/00", bus.AddrOut, bus.SizeOut); end
        // Pointer was 1 before the reset; after it master 0 must win a tie
        rst = 1'b0;
        bus.req = 2'b11;
        @(negedge clk);
        nCompared++; if (bus.grant !== 2'b01) begin nMismatched++; $display("FAIL rmid_ptr_grant: got %b want 01", bus.grant); end
        nCompared++; if (cmd !== 4'b0010) begin nMismatched++; $display("FAIL rmid_ptr_cmd: got %b want 0010", cmd); end
        rst = 1'b1; bus.req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.req = 2'b10;
        @(negedge clk);
        nCompared++; if (bus.grant !== 2'b10) begin nMismatched++; $display("FAIL rmid_req10_grant: got %b want 10", bus.grant); end
        rst = 1'b1; bus.req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset_mid: reset during burst checked");
    endtask

    task automatic test_addr_hold();
        logic [3:0] expCmd [8] = '{4'b0010, 4'b0111, 4'b0111, 4'b0111, 4'b0100, 4'b0110, 4'b1111, 4'b1111};
        logic [1:0] expDone [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        logic [1:0] expGrant [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        tcas = 8'd3; tburst = 8'd1; twait = 8'd1;
        bus.req_we = 2'b10; bus.req_addr[63:32] = 32'hA5A5_0F0F; bus.req_size[3:2] = 2'b01;
        bus.req = 2'b10;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                // CASW: change the request fields and drop req; none of it may take effect
                bus.req_addr[63:32] = 32'hFFFF_FFFF;
                bus.req_size[3:2] = 2'b11;
                bus.req_we = 2'b00;
                bus.req = 2'b00;
            end
            nCompared++; if (cmd !== expCmd[i]) begin nMismatched++; $display("FAIL hold_cmd[%0d]: got %b want %b", i, cmd, expCmd[i]); end
            nCompared++; if (bus.done !== expDone[i]) begin nMismatched++; $display("FAIL hold_done[%0d]: got %b want %b", i, bus.done, expDone[i]); end
            nCompared++; if (bus.grant !== expGrant[i]) begin nMismatched++; $display("FAIL hold_grant[%0d]: got %b want %b", i, bus.grant, expGrant[i]); end
            if (i < 6) begin
                nCompared++; if (bus.AddrOut !== 32'hA5A5_0F0F) begin nMismatched++; $display("FAIL hold_addr[%0d]: got %h want a5a50f0f", i, bus.AddrOut); end
                nCompared++; if (bus.SizeOut !== 2'b01) begin nMismatched++; $display("FAIL hold_size[%0d]: got %b want 01", i, bus.SizeOut); end
            end
        end
        $display("test_addr_hold: latched address/size/direction checked");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_boundary();
        test_reset_mid();
        test_addr_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
